// File: rtl/trap_controller_if.sv
// rtl/trap_controller_if.sv - pipeline/CSR-side signal bundle for trap_controller
interface trap_controller_if;
  logic        ext_irq;
  logic        timer_irq;
  logic        ecall;
  logic        ebreak;
  logic        mret;
  logic [31:0] ex_pc;
  logic        stall_in;
  logic        mie_global;
  logic [2:0]  mie_mask;
  logic [31:0] mepc;

  logic        trap_save;
  logic [31:0] trap_pc;
  logic        cause_valid;
  logic [2:0]  cause;
  logic        mie_we;
  logic        mie_val;
  logic        mret_we;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        in_handler;
  logic        busy;

  modport master (
    output ext_irq, timer_irq, ecall, ebreak, mret, ex_pc, stall_in,
           mie_global, mie_mask, mepc,
    input  trap_save, trap_pc, cause_valid, cause, mie_we, mie_val,
           mret_we, flush, redirect, redirect_pc, in_handler, busy
  );

  modport slave (
    input  ext_irq, timer_irq, ecall, ebreak, mret, ex_pc, stall_in,
           mie_global, mie_mask, mepc,
    output trap_save, trap_pc, cause_valid, cause, mie_we, mie_val,
           mret_we, flush, redirect, redirect_pc, in_handler, busy
  );
endinterface

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - trap sequencer: arbitrates ecall/ebreak/ext/timer,
// drains the pipeline, drives CSR write-enables and redirects fetch.
module trap_controller #(
  parameter logic [31:0] VECTOR_BASE  = 32'h0000_0100,
  parameter int          SYNC_STAGES  = 2,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  trap_controller_if.slave   tc
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [2:0] C_EXT    = 3'b001;
  localparam logic [2:0] C_TIMER  = 3'b010;
  localparam logic [2:0] C_ECALL  = 3'b100;
  localparam logic [2:0] C_EBREAK = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_TAKE,
    S_HANDLER,
    S_RETURN
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_drain_cnt;
  logic [31:0]            r_trap_pc;
  logic [2:0]             r_cause;

  logic        r_trap_save;
  logic        r_cause_valid;
  logic [2:0]  r_cause_out;
  logic        r_mie_we;
  logic        r_mie_val;
  logic        r_mret_we;
  logic        r_flush;
  logic        r_redirect;
  logic [31:0] r_redirect_pc;
  logic        r_in_handler;
  logic        r_busy;

  logic        w_ext_p;
  logic        w_tmr_p;
  logic        w_req;
  logic [2:0]  w_win_cause;
  logic        w_unused_ok;

  // Interrupts are level-sensitive and qualified live; nothing is latched.
  assign w_ext_p     = r_sync[SYNC_STAGES-1] & tc.mie_global & tc.mie_mask[0];
  assign w_tmr_p     = tc.timer_irq & tc.mie_global & tc.mie_mask[1];
  assign w_req       = tc.ebreak | tc.ecall | w_ext_p | w_tmr_p;
  assign w_unused_ok = tc.mie_mask[2];

  always_comb begin
    w_win_cause = C_TIMER;
    if (tc.ebreak)      w_win_cause = C_EBREAK;
    else if (tc.ecall)  w_win_cause = C_ECALL;
    else if (w_ext_p)   w_win_cause = C_EXT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sync        <= '0;
      r_drain_cnt   <= '0;
      r_trap_pc     <= '0;
      r_cause       <= '0;
      r_trap_save   <= 1'b0;
      r_cause_valid <= 1'b0;
      r_cause_out   <= '0;
      r_mie_we      <= 1'b0;
      r_mie_val     <= 1'b0;
      r_mret_we     <= 1'b0;
      r_flush       <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_in_handler  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], tc.ext_irq};

      // Outputs are registered for the state being entered; pulses default low.
      r_trap_save   <= 1'b0;
      r_cause_valid <= 1'b0;
      r_cause_out   <= '0;
      r_mie_we      <= 1'b0;
      r_mie_val     <= 1'b0;
      r_mret_we     <= 1'b0;
      r_flush       <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_in_handler  <= 1'b0;
      r_busy        <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_req && !tc.stall_in) begin
            r_trap_pc   <= tc.ex_pc;
            r_cause     <= w_win_cause;
            r_drain_cnt <= CNT_W'(DRAIN_CYCLES);
            r_state     <= S_DRAIN;
            r_flush     <= 1'b1;
            r_busy      <= 1'b1;
          end
        end

        S_DRAIN: begin
          r_flush <= 1'b1;
          r_busy  <= 1'b1;
          if (!tc.stall_in) begin
            if (r_drain_cnt == CNT_W'(1)) begin
              r_state       <= S_TAKE;
              r_trap_save   <= 1'b1;
              r_cause_valid <= 1'b1;
              r_cause_out   <= r_cause;
              r_mie_we      <= 1'b1;
              r_mie_val     <= 1'b0;
              r_redirect    <= 1'b1;
              r_redirect_pc <= VECTOR_BASE + {27'b0, r_cause, 2'b00};
            end else begin
              r_drain_cnt <= r_drain_cnt - CNT_W'(1);
            end
          end
        end

        S_TAKE: begin
          r_state      <= S_HANDLER;
          r_in_handler <= 1'b1;
          r_busy       <= 1'b1;
        end

        S_HANDLER: begin
          r_busy <= 1'b1;
          // No nesting: ecall/ebreak and interrupts are not looked at here.
          if (tc.mret && !tc.stall_in) begin
            r_state       <= S_RETURN;
            r_mret_we     <= 1'b1;
            r_mie_we      <= 1'b1;
            r_mie_val     <= 1'b1;
            r_cause_valid <= 1'b1;
            r_cause_out   <= 3'b000;
            r_flush       <= 1'b1;
            r_redirect    <= 1'b1;
          end else begin
            r_in_handler <= 1'b1;
          end
        end

        S_RETURN: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tc.trap_save   = r_trap_save;
  assign tc.trap_pc     = r_trap_pc;
  assign tc.cause_valid = r_cause_valid;
  assign tc.cause       = r_cause_out;
  assign tc.mie_we      = r_mie_we;
  assign tc.mie_val     = r_mie_val;
  assign tc.mret_we     = r_mret_we;
  assign tc.flush       = r_flush;
  assign tc.redirect    = r_redirect;
  // Return target follows the CSR read-back in the RETURN cycle itself.
  assign tc.redirect_pc = (r_state == S_RETURN) ? tc.mepc : r_redirect_pc;
  assign tc.in_handler  = r_in_handler;
  assign tc.busy        = r_busy;

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - scoreboard bench for trap_controller
module tb_trap_controller;

  logic clk;
  logic rst;

  trap_controller_if bus ();

  trap_controller #(
    .VECTOR_BASE (32'h0000_0100),
    .SYNC_STAGES (2),
    .DRAIN_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tc (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        trap_save;
    logic [31:0] trap_pc;
    logic        cause_valid;
    logic [2:0]  cause;
    logic        mie_we;
    logic        mie_val;
    logic        mret_we;
    logic        flush;
    logic [31:0] redirect_pc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [75:0] w_outs;
  assign w_outs = {bus.trap_save, bus.trap_pc, bus.cause_valid, bus.cause,
                   bus.mie_we, bus.mie_val, bus.mret_we, bus.flush,
                   bus.redirect, bus.redirect_pc, bus.in_handler, bus.busy};

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t take_exp(input logic [31:0] pc, input logic [2:0] c,
                                    input logic [31:0] tgt);
    exp_t e;
    e.trap_save = 1'b1; e.trap_pc = pc; e.cause_valid = 1'b1; e.cause = c;
    e.mie_we = 1'b1; e.mie_val = 1'b0; e.mret_we = 1'b0; e.flush = 1'b1;
    e.redirect_pc = tgt;
    return e;
  endfunction

  function automatic exp_t ret_exp(input logic [31:0] saved, input logic [31:0] epc);
    exp_t e;
    e.trap_save = 1'b0; e.trap_pc = saved; e.cause_valid = 1'b1; e.cause = 3'b000;
    e.mie_we = 1'b1; e.mie_val = 1'b1; e.mret_we = 1'b1; e.flush = 1'b1;
    e.redirect_pc = epc;
    return e;
  endfunction

  // Monitor: every redirect cycle must match the oldest expected response.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.redirect === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_redirect", {48'b0, bus.redirect_pc}, 80'h0);
      end else begin
        e = q.pop_front();
        chk("ev_trap_save",   {79'b0, bus.trap_save},   {79'b0, e.trap_save});
        chk("ev_trap_pc",     {48'b0, bus.trap_pc},     {48'b0, e.trap_pc});
        chk("ev_cause_valid", {79'b0, bus.cause_valid}, {79'b0, e.cause_valid});
        chk("ev_cause",       {77'b0, bus.cause},       {77'b0, e.cause});
        chk("ev_mie_we",      {79'b0, bus.mie_we},      {79'b0, e.mie_we});
        chk("ev_mie_val",     {79'b0, bus.mie_val},     {79'b0, e.mie_val});
        chk("ev_mret_we",     {79'b0, bus.mret_we},     {79'b0, e.mret_we});
        chk("ev_flush",       {79'b0, bus.flush},       {79'b0, e.flush});
        chk("ev_redirect_pc", {48'b0, bus.redirect_pc}, {48'b0, e.redirect_pc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.ext_irq = 0; bus.timer_irq = 0; bus.ecall = 0; bus.ebreak = 0;
    bus.mret = 0; bus.ex_pc = 32'h0; bus.stall_in = 0; bus.mie_global = 1;
    bus.mie_mask = 3'b011; bus.mepc = 32'h0;
    ticks(2);
    chk("reset_outputs", {4'b0, w_outs}, 80'h0);
    rst = 1'b0;
    tick();
    chk("idle_outputs", {4'b0, w_outs}, 80'h0);

    // ecall at 0x40, no stalls: flush N+1..N+3, TAKE at N+3
    bus.ex_pc = 32'h40; bus.ecall = 1;
    q.push_back(take_exp(32'h40, 3'b100, 32'h110));
    tick(); bus.ecall = 0;
    chk("ecall_flush_n1", {79'b0, bus.flush}, 80'h1);
    tick();
    chk("ecall_flush_n2", {79'b0, bus.flush}, 80'h1);
    chk("ecall_no_save_n2", {79'b0, bus.trap_save}, 80'h0);
    tick();
    chk("ecall_save_n3", {79'b0, bus.trap_save}, 80'h1);
    bus.mie_global = 0;
    tick();
    chk("handler_active", {79'b0, bus.in_handler}, 80'h1);
    chk("handler_no_flush", {79'b0, bus.flush}, 80'h0);
    chk("handler_busy", {79'b0, bus.busy}, 80'h1);

    // mret back to 0x40
    bus.mepc = 32'h40; bus.mret = 1;
    q.push_back(ret_exp(32'h40, 32'h40));
    tick(); bus.mret = 0; bus.mie_global = 1;
    chk("ret_mret_we", {79'b0, bus.mret_we}, 80'h1);
    tick();
    chk("ret_busy_clear", {79'b0, bus.busy}, 80'h0);

    // ext + timer together: ext first, timer after return
    bus.mie_global = 0; bus.ext_irq = 1; bus.timer_irq = 1;
    ticks(3);
    bus.mie_global = 1; bus.ex_pc = 32'h200;
    q.push_back(take_exp(32'h200, 3'b001, 32'h104));
    ticks(3);
    chk("ext_take", {79'b0, bus.trap_save}, 80'h1);
    bus.mie_global = 0; bus.ext_irq = 0;
    tick();
    bus.mepc = 32'h200; bus.mret = 1;
    q.push_back(ret_exp(32'h200, 32'h200));
    tick();
    bus.mret = 0; bus.mie_global = 1; bus.ex_pc = 32'h300;
    q.push_back(take_exp(32'h300, 3'b010, 32'h108));
    tick();
    chk("timer_idle_after_ret", {79'b0, bus.busy}, 80'h0);
    tick();
    chk("timer_accepted", {79'b0, bus.busy}, 80'h1);
    ticks(2);
    chk("timer_take", {79'b0, bus.trap_save}, 80'h1);
    bus.mie_global = 0; bus.timer_irq = 0;
    tick();
    bus.mepc = 32'h300; bus.mret = 1;
    q.push_back(ret_exp(32'h300, 32'h300));
    tick(); bus.mret = 0; bus.mie_global = 1;
    tick();

    // ext with mie_global = 0 is ignored, then taken once enabled
    bus.mie_global = 0; bus.ext_irq = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("masked_ext_idle", {79'b0, bus.busy}, 80'h0);
    end
    bus.mie_global = 1; bus.ex_pc = 32'h900;
    q.push_back(take_exp(32'h900, 3'b001, 32'h104));
    tick();
    chk("unmasked_ext_busy", {79'b0, bus.busy}, 80'h1);
    ticks(2);
    chk("unmasked_ext_take", {79'b0, bus.trap_save}, 80'h1);
    bus.mie_global = 0; bus.ext_irq = 0;
    tick();
    bus.mepc = 32'h900; bus.mret = 1;
    q.push_back(ret_exp(32'h900, 32'h900));
    tick(); bus.mret = 0; bus.mie_global = 1;
    tick();

    // synchronizer latency on a fresh ext_irq edge
    bus.ext_irq = 1; bus.ex_pc = 32'hA00;
    q.push_back(take_exp(32'hA00, 3'b001, 32'h104));
    tick(); chk("sync_lat_1", {79'b0, bus.busy}, 80'h0);
    tick(); chk("sync_lat_2", {79'b0, bus.busy}, 80'h0);
    tick(); chk("sync_lat_3", {79'b0, bus.busy}, 80'h1);
    ticks(2);
    chk("sync_take", {79'b0, bus.trap_save}, 80'h1);
    bus.ext_irq = 0; bus.mie_global = 0;
    tick();
    bus.mepc = 32'hA00; bus.mret = 1;
    q.push_back(ret_exp(32'hA00, 32'hA00));
    tick(); bus.mret = 0; bus.mie_global = 1;
    tick();

    // ecall held off by stall_in for 3 cycles
    bus.stall_in = 1; bus.ecall = 1; bus.ex_pc = 32'h600;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_blocks_accept", {79'b0, bus.busy}, 80'h0);
    end
    bus.stall_in = 0; bus.ex_pc = 32'h604;
    q.push_back(take_exp(32'h604, 3'b100, 32'h110));
    tick(); bus.ecall = 0;
    chk("release_accept", {79'b0, bus.busy}, 80'h1);
    tick();
    chk("release_no_save", {79'b0, bus.trap_save}, 80'h0);
    tick();
    chk("release_take", {79'b0, bus.trap_save}, 80'h1);
    tick();
    bus.mepc = 32'h604; bus.mret = 1;
    q.push_back(ret_exp(32'h604, 32'h604));
    tick(); bus.mret = 0;
    tick();

    // ebreak beats ecall; stall freezes the drain; ecall inside handler ignored
    bus.ebreak = 1; bus.ecall = 1; bus.ex_pc = 32'h700;
    q.push_back(take_exp(32'h700, 3'b101, 32'h114));
    tick(); bus.ebreak = 0; bus.ecall = 0; bus.stall_in = 1;
    ticks(2);
    chk("drain_stall_flush", {79'b0, bus.flush}, 80'h1);
    chk("drain_stall_no_save", {79'b0, bus.trap_save}, 80'h0);
    bus.stall_in = 0;
    tick();
    chk("drain_resume_no_save", {79'b0, bus.trap_save}, 80'h0);
    tick();
    chk("drain_resume_take", {79'b0, bus.trap_save}, 80'h1);
    tick();
    bus.ecall = 1;
    ticks(2);
    bus.ecall = 0;
    chk("no_nesting", {79'b0, bus.in_handler}, 80'h1);
    bus.mepc = 32'h700; bus.mret = 1;
    q.push_back(ret_exp(32'h700, 32'h700));
    tick(); bus.mret = 0;
    tick();

    // reset mid-DRAIN aborts; mret in IDLE does nothing
    bus.ecall = 1; bus.ex_pc = 32'h800;
    tick(); bus.ecall = 0;
    chk("pre_reset_drain", {79'b0, bus.flush}, 80'h1);
    rst = 1;
    tick();
    chk("reset_abort_outputs", {4'b0, w_outs}, 80'h0);
    rst = 0;
    ticks(4);
    chk("reset_abort_idle", {4'b0, w_outs}, 80'h0);
    bus.mret = 1; bus.mepc = 32'h1234;
    tick(); bus.mret = 0;
    chk("mret_idle_ignored", {4'b0, w_outs}, 80'h0);
    ticks(2);

    chk("scoreboard_drained", 80'(q.size()), 80'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
